// File: rtl/ram_1r1w_chan_adapter_if.sv
// rtl/ram_1r1w_chan_adapter_if.sv - read/write request and response channels of the ram_1r1w adapter
interface ram_1r1w_chan_adapter_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int NUM_PARTITIONS = 4
);
   logic [ADDR_WIDTH-1:0]     rd_req_addr;
   logic [NUM_PARTITIONS-1:0] rd_req_mask;
   logic                      rd_req_valid;
   logic                      rd_req_ready;
   logic [DATA_WIDTH-1:0]     rd_resp_data;
   logic                      rd_resp_valid;
   logic                      rd_resp_ready;
   logic [ADDR_WIDTH-1:0]     wr_req_addr;
   logic [DATA_WIDTH-1:0]     wr_req_data;
   logic [NUM_PARTITIONS-1:0] wr_req_mask;
   logic                      wr_req_valid;
   logic                      wr_req_ready;
   logic                      wr_resp_valid;
   logic                      wr_resp_ready;

   modport master (
      output rd_req_addr, rd_req_mask, rd_req_valid, rd_resp_ready,
      output wr_req_addr, wr_req_data, wr_req_mask, wr_req_valid, wr_resp_ready,
      input  rd_req_ready, rd_resp_data, rd_resp_valid, wr_req_ready, wr_resp_valid
   );

   modport slave (
      input  rd_req_addr, rd_req_mask, rd_req_valid, rd_resp_ready,
      input  wr_req_addr, wr_req_data, wr_req_mask, wr_req_valid, wr_resp_ready,
      output rd_req_ready, rd_resp_data, rd_resp_valid, wr_req_ready, wr_resp_valid
   );
endinterface

// File: rtl/ram_1r1w_chan_adapter.sv
// rtl/ram_1r1w_chan_adapter.sv - valid/ready read/write channels onto a raw ram_1r1w port set
// Optional RAM_ADAPTER_RAW_FWD_EN forwards same-cycle write data into a colliding read.
module ram_1r1w_chan_adapter #(
   parameter int DATA_WIDTH      = 32,
   parameter int SIZE            = 1024,
   parameter int NUM_PARTITIONS  = 4,
   parameter int ADDR_WIDTH      = $clog2(SIZE),
   parameter int RESP_FIFO_DEPTH = 2,
   parameter int WR_ACK_MAX      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   ram_1r1w_chan_adapter_if.slave    chan,
   output logic [ADDR_WIDTH-1:0]     ram_rd_addr,
   output logic                      ram_rd_en,
   output logic [NUM_PARTITIONS-1:0] ram_rd_mask,
   input  logic [DATA_WIDTH-1:0]     ram_rd_data,
   output logic [ADDR_WIDTH-1:0]     ram_wr_addr,
   output logic [DATA_WIDTH-1:0]     ram_wr_data,
   output logic                      ram_wr_en,
   output logic [NUM_PARTITIONS-1:0] ram_wr_mask
);
   localparam int PART_W = DATA_WIDTH / NUM_PARTITIONS;
   localparam int FPW    = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;
   localparam int FCW    = $clog2(RESP_FIFO_DEPTH + 1);
   localparam int ACW    = $clog2(WR_ACK_MAX + 1);

   function automatic logic [DATA_WIDTH-1:0] expand(input logic [NUM_PARTITIONS-1:0] m);
      logic [DATA_WIDTH-1:0] e;
      e = '0;
      for (int i = 0; i < NUM_PARTITIONS; i++) e[i*PART_W +: PART_W] = {PART_W{m[i]}};
      return e;
   endfunction

   function automatic logic [FPW-1:0] next_ptr(input logic [FPW-1:0] p);
      return (p == FPW'(RESP_FIFO_DEPTH - 1)) ? '0 : p + FPW'(1);
   endfunction

   logic                      rst_state;
   logic                      rd_fire;
   logic                      wr_fire;
   logic                      ack_pop;
   logic                      inflight;
   logic [NUM_PARTITIONS-1:0] inflight_mask;
   logic [DATA_WIDTH-1:0]     beat;
   logic                      fifo_empty;
   logic                      push;
   logic                      pop;
   logic [DATA_WIDTH-1:0]     fifo_mem [RESP_FIFO_DEPTH];
   logic [FPW-1:0]            fifo_rptr;
   logic [FPW-1:0]            fifo_wptr;
   logic [FCW-1:0]            fifo_count;
   logic [ACW-1:0]            ack_cnt;

   assign rd_fire = chan.rd_req_valid & chan.rd_req_ready;
   assign wr_fire = chan.wr_req_valid & chan.wr_req_ready;
   assign ack_pop = chan.wr_resp_valid & chan.wr_resp_ready;

   assign ram_rd_en   = rd_fire;
   assign ram_rd_addr = chan.rd_req_addr;
   assign ram_rd_mask = chan.rd_req_mask;
   assign ram_wr_en   = wr_fire;
   assign ram_wr_addr = chan.wr_req_addr;
   assign ram_wr_data = chan.wr_req_data;
   assign ram_wr_mask = chan.wr_req_mask;

   // Credit covers both queued beats and the beat still coming out of the RAM.
   assign chan.rd_req_ready = !rst_state &&
      (({1'b0, fifo_count} + {{FCW{1'b0}}, inflight}) < (FCW + 1)'(RESP_FIFO_DEPTH));
   assign chan.wr_req_ready  = !rst_state && (ack_cnt < ACW'(WR_ACK_MAX));
   assign chan.wr_resp_valid = (ack_cnt != '0);

`ifdef RAM_ADAPTER_RAW_FWD_EN
   logic                      fwd_hit;
   logic [DATA_WIDTH-1:0]     fwd_data;
   logic [NUM_PARTITIONS-1:0] fwd_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_hit  <= 1'b0;
         fwd_data <= '0;
         fwd_mask <= '0;
      end else begin
         fwd_hit <= rd_fire & wr_fire & (chan.rd_req_addr == chan.wr_req_addr);
         if (rd_fire & wr_fire) begin
            fwd_data <= chan.wr_req_data;
            fwd_mask <= chan.wr_req_mask;
         end
      end
   end

   always_comb begin
      beat = ram_rd_data;
      if (fwd_hit) beat = (ram_rd_data & ~expand(fwd_mask)) | (fwd_data & expand(fwd_mask));
      beat = beat & expand(inflight_mask);
   end
`else
   assign beat = ram_rd_data & expand(inflight_mask);
`endif

   assign fifo_empty         = (fifo_count == '0);
   assign chan.rd_resp_valid = inflight | !fifo_empty;
   assign chan.rd_resp_data  = !fifo_empty ? fifo_mem[fifo_rptr] : (inflight ? beat : '0);
   assign pop                = !fifo_empty & chan.rd_resp_ready;
   // The RAM beat bypasses the FIFO only when nothing is queued ahead of it and it is taken now.
   assign push               = inflight & !(fifo_empty & chan.rd_resp_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_state     <= 1'b1;
         inflight      <= 1'b0;
         inflight_mask <= '0;
         fifo_rptr     <= '0;
         fifo_wptr     <= '0;
         fifo_count    <= '0;
         ack_cnt       <= '0;
      end else begin
         rst_state <= 1'b0;
         inflight  <= rd_fire;
         if (rd_fire) inflight_mask <= chan.rd_req_mask;
         if (push) fifo_wptr <= next_ptr(fifo_wptr);
         if (pop) fifo_rptr <= next_ptr(fifo_rptr);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + FCW'(1);
            2'b01:   fifo_count <= fifo_count - FCW'(1);
            default: fifo_count <= fifo_count;
         endcase
         case ({wr_fire, ack_pop})
            2'b10:   ack_cnt <= ack_cnt + ACW'(1);
            2'b01:   ack_cnt <= ack_cnt - ACW'(1);
            default: ack_cnt <= ack_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[fifo_wptr] <= beat;
   end
endmodule
